regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: long-latency result buffer entries (2..8).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive pipeline wins with buffer non-empty before a forced buffer slot (1..15).
REQ-003 SHALL have port iCLK, input, 1: sole clock; all state updates on posedge.
REQ-004 SHALL have port iRST, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have ports iPipeWrite/iPipeReg/iPipeData, input, 1/5/32: writeback-stage write request, register index, data.
REQ-006 SHALL have port oPipeStall, input-facing output, 1: pipeline write not accepted this cycle; writeback holds its request stable.
REQ-007 SHALL have ports iMdValid/iMdReg/iMdData, input, 1/5/32: mul/div result offer, register index, data.
REQ-008 SHALL have port oMdReady, output, 1: buffer accepts an offer this cycle.
REQ-009 SHALL have ports iIssue/iIssueReg, input, 1/5: decode issues a long-latency op targeting iIssueReg.
REQ-010 SHALL have ports oBusyMask/oSbConflict, output, 32/1: per-register pending-write flags; one-cycle pulse on issue to an already-busy register.
REQ-011 SHALL have ports oRegWrite/oWriteReg/oWriteData, output, 1/5/32: registered register-file write port drive.

Function
REQ-012 SHALL accept an offer when iMdValid && oMdReady; oMdReady = (count < DEPTH) && !iRST, no combinational path from iMdValid.
REQ-013 SHALL store accepted offers in a FIFO, oldest first; head/tail pointers wrap modulo DEPTH; push and pop in one cycle leave count unchanged.
REQ-014 SHALL use a two-state arbiter: PIPE_PRIO (pipeline request wins) and MD_FORCE (buffer head wins).
REQ-015 SHALL in PIPE_PRIO grant the pipeline when iPipeWrite, else pop the buffer head when count > 0, else grant nothing.
REQ-016 SHALL increment a starvation counter on each PIPE_PRIO pipeline grant while count > 0, clear it on any buffer pop or when count = 0, and enter MD_FORCE when it reaches STARVE_LIMIT.
REQ-017 SHALL in MD_FORCE pop the buffer head, assert oPipeStall combinationally iff iPipeWrite, clear the counter, and return to PIPE_PRIO next cycle (exactly one forced slot).
REQ-018 SHALL register the granted write: oRegWrite/oWriteReg/oWriteData valid the cycle after the grant (latency 1).
REQ-019 SHALL drop writes to register 0: oRegWrite stays 0, grant and pop still occur.
REQ-020 SHALL hold oRegWrite at 0 in cycles with no grant; oWriteReg/oWriteData keep previous values.
REQ-021 SHALL set oBusyMask[iIssueReg] on iIssue (index 0 ignored) and clear oBusyMask[r] on the cycle a buffer entry for r is popped.
REQ-022 SHALL give set priority over clear when issue and pop target the same register in one cycle.
REQ-023 SHALL pulse oSbConflict the cycle after iIssue to a register whose bit is already set and not being cleared; mask bit stays set.
REQ-024 SHALL not accept an offer and pop it in the same cycle (no bypass through the buffer).

Reset
REQ-025 SHALL on iRST: empty buffer, pointers 0, state PIPE_PRIO, starvation counter 0, oBusyMask 0, oSbConflict 0, oRegWrite 0, oWriteReg 0, oWriteData 0.
REQ-026 SHALL during iRST force oMdReady 0 and oPipeStall 0; buffered results are discarded, no write issued.

Configuration
REQ-027 SHALL compile scoreboard logic only when REGARB_SCOREBOARD_EN is defined; otherwise oBusyMask and oSbConflict tie to 0, iIssue/iIssueReg are ignored, arbitration unchanged.

Verification
REQ-028 SHALL cover: reset, then iPipeWrite=1 reg 5 data 0xDEADBEEF -> next cycle oRegWrite=1, oWriteReg=5, oWriteData=0xDEADBEEF.
REQ-029 SHALL cover: DEPTH=2, three back-to-back offers with pipeline writing continuously -> oMdReady=0 after second acceptance; with STARVE_LIMIT=4, fifth cycle oPipeStall=1 and head entry written next cycle.
REQ-030 SHALL cover: offer reg 0 data 0x1234 with idle pipeline -> entry popped, oRegWrite stays 0, count returns to 0.
REQ-031 SHALL cover (macro on): iIssue reg 7, later pop of reg-7 entry coincident with iIssue reg 7 -> oBusyMask[7] remains 1, oSbConflict=0; second iIssue reg 7 while busy -> oSbConflict pulses 1.
REQ-032 SHALL cover: iRST asserted with 2 buffered entries and MD_FORCE pending -> next cycle count 0, oRegWrite 0, oBusyMask 0, oMdReady 0 during reset then 1.
REQ-033 SHALL cover (macro off): iIssue reg 9 -> oBusyMask stays 0x00000000.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between the writeback stage of
//   the pipeline and a small FIFO of long-latency (mul/div) results.
//   The pipeline normally has priority. If the FIFO stays non-empty while the
//   pipeline wins STARVE_LIMIT times in a row, one slot is forced for the FIFO
//   head and the pipeline is stalled for that one cycle.
//   The granted write is registered, so it reaches the register file one
//   cycle after the grant. Writes to register 0 are granted and popped but
//   never reach the register file.
//
// Optional feature:
//   REGARB_SCOREBOARD_EN - when defined, a 32-entry pending-write scoreboard
//   is built (oBusyMask / oSbConflict). When undefined, both outputs are tied
//   to 0 and iIssue/iIssueReg are ignored. Arbitration is the same either way.
//
// Handshake rules:
//   - mul/div offer: an offer is taken on any cycle with iMdValid && oMdReady.
//     oMdReady depends only on registered state and iRST, never on iMdValid.
//   - pipeline write: the write is taken on any cycle with
//     iPipeWrite && !oPipeStall. While stalled, writeback holds
//     iPipeWrite/iPipeReg/iPipeData stable.
//
// Parameters:
//   DEPTH        - FIFO entries (2..8)
//   STARVE_LIMIT - pipeline wins in a row with a non-empty FIFO before a
//                  forced FIFO slot (1..15)
//
// Ports:
//   iCLK, iRST                        clock, synchronous active-high reset
//   iPipeWrite/iPipeReg/iPipeData     writeback write request
//   oPipeStall                        pipeline write refused this cycle
//   iMdValid/iMdReg/iMdData           mul/div result offer
//   oMdReady                          FIFO can take an offer this cycle
//   iIssue/iIssueReg                  long-latency op issued to iIssueReg
//   oBusyMask                         per-register pending-write flags
//   oSbConflict                       pulse: issue to a register already busy
//   oRegWrite/oWriteReg/oWriteData    registered register-file write port
//   oDbgState                         arbiter state (0 PIPE_PRIO, 1 MD_FORCE)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iPipeWrite,
  input  logic [4:0]  iPipeReg,
  input  logic [31:0] iPipeData,
  output logic        oPipeStall,
  input  logic        iMdValid,
  input  logic [4:0]  iMdReg,
  input  logic [31:0] iMdData,
  output logic        oMdReady,
  input  logic        iIssue,
  input  logic [4:0]  iIssueReg,
  output logic [31:0] oBusyMask,
  output logic        oSbConflict,
  output logic        oRegWrite,
  output logic [4:0]  oWriteReg,
  output logic [31:0] oWriteData,
  output logic        oDbgState
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0]    STARVE_C = 4'(STARVE_LIMIT);

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    MD_FORCE  = 1'b1
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    starve_q, starve_d;

  logic [4:0]    buf_reg_q  [DEPTH];
  logic [31:0]   buf_data_q [DEPTH];

  logic          push;
  logic          pop;
  logic          grant_pipe;
  logic          grant_valid;
  logic [4:0]    grant_reg;
  logic [31:0]   grant_data;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;

  logic          reg_write_q;
  logic [4:0]    write_reg_q;
  logic [31:0]   write_data_q;

  // ---------------------------------------------------------------------------
  // FIFO accept side. Ready comes only from the registered count, so there is
  // no combinational path from iMdValid to oMdReady.
  // ---------------------------------------------------------------------------
  assign oMdReady = (count_q < DEPTH_C) && !iRST;
  assign push     = iMdValid && oMdReady;

  assign head_reg  = buf_reg_q[head_q];
  assign head_data = buf_data_q[head_q];

  // ---------------------------------------------------------------------------
  // Arbiter: next state, grant selection, starvation counter, stall.
  // Pops look only at the registered count, so an entry accepted this cycle
  // can never be popped in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pop        = 1'b0;
    grant_pipe = 1'b0;
    oPipeStall = 1'b0;

    unique case (state_q)
      PIPE_PRIO: begin
        if (iPipeWrite) begin
          grant_pipe = 1'b1;
          // Only wins taken while results are waiting count as starvation.
          if (count_q != '0) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (count_q != '0) begin
          pop      = 1'b1;
          starve_d = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
        if (starve_d == STARVE_C) begin
          state_d = MD_FORCE;
        end
      end
      MD_FORCE: begin
        // Exactly one forced slot; the FIFO is never empty here because the
        // counter only advances while it holds entries and nothing pops in
        // between, but the guard keeps a spurious pop impossible.
        pop        = (count_q != '0);
        oPipeStall = iPipeWrite;
        starve_d   = 4'd0;
        state_d    = PIPE_PRIO;
      end
      default: begin
        state_d  = PIPE_PRIO;
        starve_d = 4'd0;
      end
    endcase

    if (iRST) begin
      oPipeStall = 1'b0;
    end
  end

  assign grant_valid = grant_pipe || pop;
  assign grant_reg   = grant_pipe ? iPipeReg  : head_reg;
  assign grant_data  = grant_pipe ? iPipeData : head_data;

  // ---------------------------------------------------------------------------
  // FIFO pointer and occupancy update. Pointers wrap modulo DEPTH, which need
  // not be a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PW'(1);
    end
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= PIPE_PRIO;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage holds payload only; validity is tracked by count/pointers,
  // so the array needs no reset.
  always_ff @(posedge iCLK) begin
    if (push) begin
      buf_reg_q[tail_q]  <= iMdReg;
      buf_data_q[tail_q] <= iMdData;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port. Register 0 grants still load reg/data but never
  // raise oRegWrite; cycles without a grant keep the last reg/data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      reg_write_q <= grant_valid && (grant_reg != 5'd0);
      if (grant_valid) begin
        write_reg_q  <= grant_reg;
        write_data_q <= grant_data;
      end
    end
  end

  assign oRegWrite  = reg_write_q;
  assign oWriteReg  = write_reg_q;
  assign oWriteData = write_data_q;
  assign oDbgState  = state_q;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard.
  // ---------------------------------------------------------------------------
`ifdef REGARB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        conflict_q, conflict_d;
  logic        clear_same;

  // A pop clearing the very register being issued means the old pending write
  // retires now, so the new issue is not a conflict.
  assign clear_same = pop && (head_reg == iIssueReg);

  always_comb begin
    busy_d     = busy_q;
    conflict_d = 1'b0;
    if (pop) begin
      busy_d[head_reg] = 1'b0;
    end
    // Set after clear so a same-cycle issue wins over the retiring pop.
    if (iIssue && (iIssueReg != 5'd0)) begin
      conflict_d        = busy_q[iIssueReg] && !clear_same;
      busy_d[iIssueReg] = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      busy_q     <= 32'd0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign oBusyMask   = busy_q;
  assign oSbConflict = conflict_q;
`else
  logic unused_issue;
  assign unused_issue = ^{iIssue, iIssueReg};
  assign oBusyMask    = 32'd0;
  assign oSbConflict  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed scenarios with literal expectations, followed by random traffic.
// A behavioural model (FIFO as a queue, starvation as a plain integer and a
// "forced slot owed" flag) predicts every output and is compared on each
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        iCLK;
  logic        iRST;
  logic        iPipeWrite;
  logic [4:0]  iPipeReg;
  logic [31:0] iPipeData;
  logic        oPipeStall;
  logic        iMdValid;
  logic [4:0]  iMdReg;
  logic [31:0] iMdData;
  logic        oMdReady;
  logic        iIssue;
  logic [4:0]  iIssueReg;
  logic [31:0] oBusyMask;
  logic        oSbConflict;
  logic        oRegWrite;
  logic [4:0]  oWriteReg;
  logic [31:0] oWriteData;
  logic        oDbgState;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iPipeWrite (iPipeWrite),
    .iPipeReg   (iPipeReg),
    .iPipeData  (iPipeData),
    .oPipeStall (oPipeStall),
    .iMdValid   (iMdValid),
    .iMdReg     (iMdReg),
    .iMdData    (iMdData),
    .oMdReady   (oMdReady),
    .iIssue     (iIssue),
    .iIssueReg  (iIssueReg),
    .oBusyMask  (oBusyMask),
    .oSbConflict(oSbConflict),
    .oRegWrite  (oRegWrite),
    .oWriteReg  (oWriteReg),
    .oWriteData (oWriteData),
    .oDbgState  (oDbgState)
  );

  // ---------------- clock ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve = 0;
  bit          m_force  = 0;
  bit          m_wr     = 0;
  logic [4:0]  m_reg    = 5'd0;
  logic [31:0] m_data   = 32'd0;
  bit          m_known  = 1;
  logic [31:0] m_busy   = 32'd0;
  bit          m_conf   = 0;
  bit          model_on = 0;

  always @(negedge iCLK) begin : model_cmp
    int   n;
    bit   exp_ready;
    bit   do_pop;
    bit   gp;
    ent_t e;

    n         = m_q.size();
    exp_ready = !iRST && (n < DEPTH);

    if (model_on) begin
      chk("md_ready",  32'(oMdReady),   32'(exp_ready));
      chk("pipe_stall", 32'(oPipeStall), 32'(!iRST && m_force && iPipeWrite));
      chk("reg_write", 32'(oRegWrite),  32'(m_wr));
      if (m_known) begin
        chk("write_reg",  32'(oWriteReg), 32'(m_reg));
        chk("write_data", oWriteData,     m_data);
      end
      chk("busy_mask",   oBusyMask,         m_busy);
      chk("sb_conflict", 32'(oSbConflict),  32'(m_conf));
    end

    if (iRST) begin
      m_q.delete();
      m_starve = 0;
      m_force  = 0;
      m_wr     = 0;
      m_reg    = 5'd0;
      m_data   = 32'd0;
      m_known  = 1;
      m_busy   = 32'd0;
      m_conf   = 0;
      model_on = 1;
    end else begin
      do_pop = 0;
      gp     = 0;
      if (m_force) begin
        do_pop   = (n > 0);
        m_starve = 0;
        m_force  = 0;
      end else if (iPipeWrite) begin
        gp = 1;
        if (n > 0) m_starve = m_starve + 1;
        else       m_starve = 0;
        if (m_starve == STARVE_LIMIT) m_force = 1;
      end else begin
        do_pop   = (n > 0);
        m_starve = 0;
      end

      e = '0;
      if (do_pop) e = m_q.pop_front();

`ifdef REGARB_SCOREBOARD_EN
      m_conf = 0;
      if (iIssue && iIssueReg != 5'd0)
        m_conf = m_busy[iIssueReg] && !(do_pop && e.r == iIssueReg);
      if (do_pop) m_busy[e.r] = 1'b0;
      if (iIssue && iIssueReg != 5'd0) m_busy[iIssueReg] = 1'b1;
`endif

      if (gp) begin
        m_wr    = (iPipeReg != 5'd0);
        m_reg   = iPipeReg;
        m_data  = iPipeData;
        m_known = (iPipeReg != 5'd0);
      end else if (do_pop) begin
        m_wr    = (e.r != 5'd0);
        m_reg   = e.r;
        m_data  = e.d;
        m_known = (e.r != 5'd0);
      end else begin
        m_wr = 0;
      end

      if (exp_ready && iMdValid) m_q.push_back('{r: iMdReg, d: iMdData});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    iPipeWrite = 1'b0;
    iPipeReg   = 5'd0;
    iPipeData  = 32'd0;
    iMdValid   = 1'b0;
    iMdReg     = 5'd0;
    iMdData    = 32'd0;
    iIssue     = 1'b0;
    iIssueReg  = 5'd0;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit hold_pipe;

    iRST = 1'b1;
    idle();
    tick();
    tick();

    // reset state
    chk("rst_reg_write",  32'(oRegWrite),   32'd0);
    chk("rst_write_reg",  32'(oWriteReg),   32'd0);
    chk("rst_write_data", oWriteData,       32'd0);
    chk("rst_busy",       oBusyMask,        32'd0);
    chk("rst_conflict",   32'(oSbConflict), 32'd0);
    chk("rst_ready",      32'(oMdReady),    32'd0);
    chk("rst_stall",      32'(oPipeStall),  32'd0);
    iRST = 1'b0;
    #1;
    chk("ready_after_rst", 32'(oMdReady), 32'd1);

    // pipeline write reaches the port one cycle later
    iPipeWrite = 1'b1;
    iPipeReg   = 5'd5;
    iPipeData  = 32'hDEADBEEF;
    tick();
    chk("pw_reg_write",  32'(oRegWrite), 32'd1);
    chk("pw_write_reg",  32'(oWriteReg), 32'd5);
    chk("pw_write_data", oWriteData,     32'hDEADBEEF);
    idle();
    tick();
    chk("idle_reg_write", 32'(oRegWrite), 32'd0);
    chk("idle_hold_reg",  32'(oWriteReg), 32'd5);

    // starvation: three offers against a continuously writing pipeline
    iPipeWrite = 1'b1;
    iPipeReg   = 5'd1;
    iPipeData  = 32'h1111_0000;
    iMdValid   = 1'b1;
    iMdReg     = 5'd10;
    iMdData    = 32'hA000_000A;
    #1;
    chk("st_ready_1", 32'(oMdReady), 32'd1);
    tick();
    iMdReg  = 5'd11;
    iMdData = 32'hB000_000B;
    #1;
    chk("st_ready_2", 32'(oMdReady), 32'd1);
    tick();
    iMdReg  = 5'd12;
    iMdData = 32'hC000_000C;
    #1;
    chk("st_ready_full", 32'(oMdReady), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("st_no_stall", 32'(oPipeStall), 32'd0);
      tick();
    end
    chk("st_stall",      32'(oPipeStall), 32'd1);
    chk("st_ready_held", 32'(oMdReady),   32'd0);
    tick();
    chk("st_force_write", 32'(oRegWrite), 32'd1);
    chk("st_force_reg",   32'(oWriteReg), 32'd10);
    chk("st_force_data",  oWriteData,     32'hA000_000A);
    chk("st_stall_gone",  32'(oPipeStall), 32'd0);
    chk("st_ready_again", 32'(oMdReady),  32'd1);
    tick();
    chk("st_pipe_reg", 32'(oWriteReg), 32'd1);
    iMdValid   = 1'b0;
    iPipeWrite = 1'b0;
    tick();
    chk("st_drain_b", oWriteData, 32'hB000_000B);
    tick();
    chk("st_drain_c", 32'(oWriteReg), 32'd12);
    tick();
    chk("st_drained", 32'(oRegWrite), 32'd0);

    // offer to register 0 is popped but never written
    idle();
    iMdValid = 1'b1;
    iMdReg   = 5'd0;
    iMdData  = 32'h0000_1234;
    tick();
    idle();
    tick();
    chk("r0_no_write", 32'(oRegWrite), 32'd0);
    tick();
    chk("r0_still_no_write", 32'(oRegWrite), 32'd0);
    chk("r0_ready",          32'(oMdReady),  32'd1);

`ifdef REGARB_SCOREBOARD_EN
    // scoreboard: set beats clear, then a real conflict
    iIssue    = 1'b1;
    iIssueReg = 5'd7;
    tick();
    iIssue = 1'b0;
    chk("sb_busy7", 32'(oBusyMask[7]), 32'd1);
    iMdValid   = 1'b1;
    iMdReg     = 5'd7;
    iMdData    = 32'h0000_7777;
    iPipeWrite = 1'b1;
    iPipeReg   = 5'd2;
    tick();
    iMdValid   = 1'b0;
    iPipeWrite = 1'b0;
    iIssue     = 1'b1;
    iIssueReg  = 5'd7;
    tick();
    chk("sb_set_wins",  32'(oBusyMask[7]),  32'd1);
    chk("sb_no_confl",  32'(oSbConflict),   32'd0);
    chk("sb_pop_reg",   32'(oWriteReg),     32'd7);
    tick();
    chk("sb_conflict",  32'(oSbConflict),   32'd1);
    chk("sb_still_set", 32'(oBusyMask[7]),  32'd1);
    iIssue = 1'b0;
    tick();
    chk("sb_pulse_end", 32'(oSbConflict),   32'd0);
    iMdValid = 1'b1;
    iMdReg   = 5'd7;
    tick();
    iMdValid = 1'b0;
    tick();
    chk("sb_cleared", oBusyMask, 32'd0);
`else
    iIssue    = 1'b1;
    iIssueReg = 5'd9;
    tick();
    iIssue = 1'b0;
    tick();
    chk("nosb_busy",     oBusyMask,        32'd0);
    chk("nosb_conflict", 32'(oSbConflict), 32'd0);
`endif

    // reset while two entries wait and a forced slot is owed
    idle();
    iIssue     = 1'b1;
    iIssueReg  = 5'd3;
    iPipeWrite = 1'b1;
    iPipeReg   = 5'd4;
    iPipeData  = 32'h4444_4444;
    iMdValid   = 1'b1;
    iMdReg     = 5'd13;
    iMdData    = 32'hD000_000D;
    tick();
    iIssue = 1'b0;
    iMdReg = 5'd14;
    tick();
    iMdValid = 1'b0;
    tick();
    tick();
    tick();
    chk("rs_force_owed", 32'(oPipeStall), 32'd1);
    iRST = 1'b1;
    #1;
    chk("rs_stall_in_rst", 32'(oPipeStall), 32'd0);
    chk("rs_ready_in_rst", 32'(oMdReady),   32'd0);
    tick();
    chk("rs_reg_write", 32'(oRegWrite), 32'd0);
    chk("rs_busy",      oBusyMask,      32'd0);
    chk("rs_ready_low", 32'(oMdReady),  32'd0);
    iRST = 1'b0;
    idle();
    #1;
    chk("rs_ready_high", 32'(oMdReady), 32'd1);
    tick();
    chk("rs_no_stale_write", 32'(oRegWrite), 32'd0);

    // random traffic
    hold_pipe = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold_pipe) begin
        iPipeWrite = ($urandom_range(0, 3) != 0);
        iPipeReg   = 5'($urandom_range(0, 31));
        iPipeData  = $urandom;
      end
      iMdValid  = ($urandom_range(0, 2) == 0);
      iMdReg    = 5'($urandom_range(0, 7));
      iMdData   = $urandom;
      iIssue    = ($urandom_range(0, 3) == 0);
      iIssueReg = 5'($urandom_range(0, 7));
      iRST      = ($urandom_range(0, 149) == 0);
      #1;
      hold_pipe = iPipeWrite && oPipeStall && !iRST;
      tick();
    end

    iRST = 1'b0;
    idle();
    tick();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
